// File: rtl/layer_stream_sequencer.sv
// Layer-to-layer burst sequencer: captures a finished layer into the intermediate
// buffer, then streams NUM_NEURONS indexed words. Optional macro: LAYER_STREAM_SEQUENCER_OVERRUN_EN.
module layer_stream_sequencer #(
    parameter int NUM_NEURONS = 4,
    parameter int IDX_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 layer_done,
    input  logic                 next_ready,
    output logic                 inter_en,
    output logic                 layer_ack,
    output logic                 stream_valid,
    output logic [IDX_WIDTH-1:0] neuron_idx,
    output logic                 burst_done,
`ifdef LAYER_STREAM_SEQUENCER_OVERRUN_EN
    output logic                 overrun,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2
    } state_e;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    state_e               state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 armed_q, armed_d;
    logic                 inter_en_q, inter_en_d;
    logic                 layer_ack_q, layer_ack_d;
    logic                 stream_valid_q, stream_valid_d;
    logic [IDX_WIDTH-1:0] neuron_idx_q, neuron_idx_d;
    logic                 burst_done_q, burst_done_d;
    logic                 busy_q, busy_d;

    logic ld_eff;
    logic last_word;

    // The first edge after reset release only arms the block; layer_done is ignored there.
    assign ld_eff    = layer_done & armed_q;
    assign armed_d   = 1'b1;
    assign last_word = (state_q == STREAM) && (neuron_idx_q == LAST_IDX);

    // State register and all output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pending_q      <= 1'b0;
            armed_q        <= 1'b0;
            inter_en_q     <= 1'b0;
            layer_ack_q    <= 1'b0;
            stream_valid_q <= 1'b0;
            neuron_idx_q   <= '0;
            burst_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            pending_q      <= pending_d;
            armed_q        <= armed_d;
            inter_en_q     <= inter_en_d;
            layer_ack_q    <= layer_ack_d;
            stream_valid_q <= stream_valid_d;
            neuron_idx_q   <= neuron_idx_d;
            burst_done_q   <= burst_done_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state and pending-request logic.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d   = state_q;
        pending_d = pending_q | ld_eff;
        unique case (state_q)
            IDLE: begin
                if ((pending_q || ld_eff) && next_ready) begin
                    state_d   = CAPTURE;
                    pending_d = 1'b0;
                end
            end
            CAPTURE: state_d = STREAM;
            STREAM: begin
                if (last_word) begin
                    if (pending_q && next_ready) begin
                        state_d   = CAPTURE;
                        // Only the old request is consumed; a pulse on this edge stays queued.
                        pending_d = ld_eff;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so each one leaves a flop.
    always_comb begin
        neuron_idx_d = '0;
        if (state_q == STREAM && !last_word) begin
            neuron_idx_d = neuron_idx_q + IDX_WIDTH'(1);
        end
        inter_en_d     = (state_d == CAPTURE);
        layer_ack_d    = (state_d == CAPTURE);
        stream_valid_d = (state_d == STREAM);
        burst_done_d   = (state_d == STREAM) && (neuron_idx_d == LAST_IDX);
        busy_d         = (state_d != IDLE) || pending_d;
    end

    assign inter_en     = inter_en_q;
    assign layer_ack    = layer_ack_q;
    assign stream_valid = stream_valid_q;
    assign neuron_idx   = neuron_idx_q;
    assign burst_done   = burst_done_q;
    assign busy         = busy_q;

`ifdef LAYER_STREAM_SEQUENCER_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky: a second request arrived before the first one was captured.
    assign overrun_d = overrun_q | (ld_eff & pending_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Scoreboard bench for layer_stream_sequencer: expected burst words are queued when a
// request is driven and popped by a monitor whenever stream_valid is seen.
module tb_layer_stream_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       layer_done = 1'b0;
    logic       next_ready = 1'b0;
    logic       inter_en, layer_ack, stream_valid, burst_done, busy;
    logic [7:0] neuron_idx;
`ifdef LAYER_STREAM_SEQUENCER_OVERRUN_EN
    logic       overrun;
`endif

    logic       ld1 = 1'b0;
    logic       nr1 = 1'b0;
    logic       ie1, la1, sv1, bd1, busy1;
    logic [1:0] idx1;

    int tests_run = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] idx;
        logic       last;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    layer_stream_sequencer #(.NUM_NEURONS(4), .IDX_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .layer_done   (layer_done),
        .next_ready   (next_ready),
        .inter_en     (inter_en),
        .layer_ack    (layer_ack),
        .stream_valid (stream_valid),
        .neuron_idx   (neuron_idx),
        .burst_done   (burst_done),
`ifdef LAYER_STREAM_SEQUENCER_OVERRUN_EN
        .overrun      (overrun),
`endif
        .busy         (busy)
    );

    layer_stream_sequencer #(.NUM_NEURONS(1), .IDX_WIDTH(2)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .layer_done   (ld1),
        .next_ready   (nr1),
        .inter_en     (ie1),
        .layer_ack    (la1),
        .stream_valid (sv1),
        .neuron_idx   (idx1),
        .burst_done   (bd1),
`ifdef LAYER_STREAM_SEQUENCER_OVERRUN_EN
        .overrun      (),
`endif
        .busy         (busy1)
    );

    // Scoreboard monitor: every live word must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && stream_valid === 1'b1) begin
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_word: idx=%0d burst_done=%0b with empty queue", neuron_idx, burst_done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (neuron_idx !== e.idx || burst_done !== e.last) begin
                    fails++;
                    $display("FAIL sb_word: got idx=%0d burst_done=%0b, expected idx=%0d burst_done=%0b",
                             neuron_idx, burst_done, e.idx, e.last);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst();
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.idx  = 8'(i);
            e.last = (i == 3);
            sb.push_back(e);
        end
    endtask

    function automatic logic [12:0] observed();
        return {inter_en, layer_ack, stream_valid, burst_done, busy, neuron_idx};
    endfunction

    // Expected {inter_en, layer_ack, stream_valid, burst_done, busy, idx} k cycles after a lone request.
    function automatic logic [12:0] exp_single(int k);
        logic       sv;
        logic [7:0] idx;
        sv  = (k >= 2 && k <= 5);
        idx = sv ? 8'(k - 2) : 8'd0;
        return {k == 1, k == 1, sv, k == 5, k <= 5, idx};
    endfunction

    // Same, with a second request queued during the first burst.
    function automatic logic [12:0] exp_b2b(int k);
        logic       ie, sv1st, sv2nd;
        logic [7:0] idx;
        ie    = (k == 1 || k == 6);
        sv1st = (k >= 2 && k <= 5);
        sv2nd = (k >= 7 && k <= 10);
        idx   = sv1st ? 8'(k - 2) : (sv2nd ? 8'(k - 7) : 8'd0);
        return {ie, ie, sv1st | sv2nd, k == 5 || k == 10, k <= 10, idx};
    endfunction

    task automatic wait_idle(string name);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            cyc();
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, expected 0", name, busy, n);
        end
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_sb_leftover: %0d words never streamed, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        tests_run++;
        if (observed() !== 13'd0 || {ie1, la1, sv1, bd1, busy1, idx1} !== 7'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b / %b, expected all 0", observed(), {ie1, la1, sv1, bd1, busy1, idx1});
        end
`ifdef LAYER_STREAM_SEQUENCER_OVERRUN_EN
        tests_run++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_overrun: got %b, expected 0", overrun);
        end
`endif
        // layer_done on the first edge after release must be ignored.
        rst_n      = 1'b1;
        layer_done = 1'b1;
        next_ready = 1'b1;
        cyc();
        layer_done = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tests_run++;
            if (busy !== 1'b0 || inter_en !== 1'b0) begin
                fails++;
                $display("FAIL reset_first_edge_ignore: cycle %0d busy=%0b inter_en=%0b, expected 0 0", k, busy, inter_en);
            end
            cyc();
        end
    endtask

    task automatic test_single_burst();
        layer_done = 1'b1;
        next_ready = 1'b1;
        push_burst();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            layer_done = 1'b0;
            tests_run++;
            if (observed() !== exp_single(k)) begin
                fails++;
                $display("FAIL single_burst: cycle %0d got %b, expected %b", k, observed(), exp_single(k));
            end
        end
        wait_idle("single_burst");
    endtask

    task automatic test_back_pressure();
        layer_done = 1'b1;
        next_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            layer_done = (k == 3);
            tests_run++;
            if (busy !== 1'b1 || inter_en !== 1'b0 || stream_valid !== 1'b0) begin
                fails++;
                $display("FAIL back_pressure_hold: cycle %0d busy=%0b inter_en=%0b stream_valid=%0b, expected 1 0 0",
                         k, busy, inter_en, stream_valid);
            end
            if (k == 10) begin
                next_ready = 1'b1;
                push_burst();
            end
        end
        cyc();
        tests_run++;
        if (inter_en !== 1'b1 || layer_ack !== 1'b1) begin
            fails++;
            $display("FAIL back_pressure_release: cycle 11 inter_en=%0b layer_ack=%0b, expected 1 1", inter_en, layer_ack);
        end
        wait_idle("back_pressure");
    endtask

    task automatic test_back_to_back();
        layer_done = 1'b1;
        next_ready = 1'b1;
        push_burst();
        for (int k = 1; k <= 11; k++) begin
            cyc();
            layer_done = (k == 3);
            if (k == 3) push_burst();
            tests_run++;
            if (observed() !== exp_b2b(k)) begin
                fails++;
                $display("FAIL back_to_back: cycle %0d got %b, expected %b", k, observed(), exp_b2b(k));
            end
        end
        wait_idle("back_to_back");
    endtask

    task automatic test_ready_drop();
        layer_done = 1'b1;
        next_ready = 1'b1;
        push_burst();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            layer_done = 1'b0;
            if (k == 2) next_ready = 1'b0;
            tests_run++;
            if (observed() !== exp_single(k)) begin
                fails++;
                $display("FAIL ready_drop: cycle %0d got %b, expected %b", k, observed(), exp_single(k));
            end
        end
        next_ready = 1'b1;
        wait_idle("ready_drop");
    endtask

    task automatic test_reset_mid_burst();
        layer_done = 1'b1;
        next_ready = 1'b1;
        push_burst();
        repeat (4) begin
            cyc();
            layer_done = 1'b0;
        end
        tests_run++;
        if (neuron_idx !== 8'd2) begin
            fails++;
            $display("FAIL reset_mid_setup: idx=%0d, expected 2", neuron_idx);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (observed() !== 13'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b, expected all 0", observed());
        end
        sb.delete();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        tests_run++;
        if (busy !== 1'b0 || stream_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_abandon: busy=%0b stream_valid=%0b, expected 0 0", busy, stream_valid);
        end
        layer_done = 1'b1;
        push_burst();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            layer_done = 1'b0;
            tests_run++;
            if (observed() !== exp_single(k)) begin
                fails++;
                $display("FAIL reset_mid_fresh: cycle %0d got %b, expected %b", k, observed(), exp_single(k));
            end
        end
        wait_idle("reset_mid");
    endtask

    task automatic test_single_neuron();
        logic [6:0] exp1;
        ld1 = 1'b1;
        nr1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            ld1 = 1'b0;
            case (k)
                1:       exp1 = 7'b11_0_0_1_00;
                2:       exp1 = 7'b00_1_1_1_00;
                default: exp1 = 7'b00_0_0_0_00;
            endcase
            tests_run++;
            if ({ie1, la1, sv1, bd1, busy1, idx1} !== exp1) begin
                fails++;
                $display("FAIL single_neuron: cycle %0d got %b, expected %b", k, {ie1, la1, sv1, bd1, busy1, idx1}, exp1);
            end
        end
    endtask

`ifdef LAYER_STREAM_SEQUENCER_OVERRUN_EN
    task automatic test_overrun();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        layer_done = 1'b1;
        next_ready = 1'b1;
        push_burst();
        for (int k = 1; k <= 11; k++) begin
            cyc();
            layer_done = (k == 2 || k == 4);
            if (k == 2) push_burst();
            tests_run++;
            if (observed() !== exp_b2b(k) || overrun !== (k >= 5)) begin
                fails++;
                $display("FAIL overrun: cycle %0d got %b ovr=%0b, expected %b ovr=%0b",
                         k, observed(), overrun, exp_b2b(k), (k >= 5));
            end
        end
        wait_idle("overrun");
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_back_pressure();
        test_back_to_back();
        test_ready_drop();
        test_reset_mid_burst();
        test_single_neuron();
`ifdef LAYER_STREAM_SEQUENCER_OVERRUN_EN
        test_overrun();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
